// File: rtl/encoder_4x2_seq.sv
// encoder_4x2_seq: sequential 4-to-2 priority encoder with a valid/ready
// handshake on both sides. It accepts a 4-bit request word and emits the index
// of every set bit, highest bit first, one index per downstream handshake.
// Optional build macro MULTIHOT_ERR_EN: when defined, a sticky err flag is
// built that sets on accepting a word with more than one bit set. When it is
// undefined, err_o is tied to 0.
module encoder_4x2_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] D_i,
  input  logic       D_valid_i,
  output logic       D_ready_o,
  output logic [1:0] A_o,
  output logic       A_valid_o,
  input  logic       A_ready_i,
  output logic       err_o,
  output logic [7:0] word_cnt_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx;
  logic [3:0] pend_clr;
  logic       accept;

  assign accept = D_valid_i && (state_q == IDLE);

  // Highest set bit of the pending mask (bit 3 wins).
  always_comb begin
    idx = 2'd0;
    if      (pend_q[3]) idx = 2'd3;
    else if (pend_q[2]) idx = 2'd2;
    else if (pend_q[1]) idx = 2'd1;
    else                idx = 2'd0;
  end

  assign pend_clr = pend_q & ~(4'b0001 << idx);

  // State, pending mask and word counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: latch a word in IDLE (zero words are dropped), then clear one
  // bit per handshake in EMIT, returning to IDLE once the mask drains.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (D_valid_i) begin
          pend_d = D_i;
          if (D_i != 4'b0000) state_d = EMIT;
        end
      end
      EMIT: begin
        if (A_ready_i) begin
          pend_d = pend_clr;
          if (pend_clr == 4'b0000) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign D_ready_o  = (state_q == IDLE);
  assign A_valid_o  = (state_q == EMIT);
  assign A_o        = (state_q == EMIT) ? idx : 2'b00;
  assign word_cnt_o = cnt_q;

`ifdef MULTIHOT_ERR_EN
  logic err_q;

  // Sticky multi-hot flag: (D & (D-1)) is nonzero when more than one bit is set.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (accept && ((D_i & (D_i - 4'd1)) != 4'b0000))
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Directed bench for encoder_4x2_seq with hand-computed expectations.
module tb_encoder_4x2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       D_valid;
  logic       D_ready;
  logic [1:0] A;
  logic       A_valid;
  logic       A_ready;
  logic       err;
  logic [7:0] word_cnt;

  int n_chk = 0;
  int n_err = 0;

`ifdef MULTIHOT_ERR_EN
  localparam logic [7:0] ERR_EXP = 8'd1;
`else
  localparam logic [7:0] ERR_EXP = 8'd0;
`endif

  encoder_4x2_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .D_i        (D),
    .D_valid_i  (D_valid),
    .D_ready_o  (D_ready),
    .A_o        (A),
    .A_valid_o  (A_valid),
    .A_ready_i  (A_ready),
    .err_o      (err),
    .word_cnt_o (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".D_ready"}, {7'd0, D_ready}, 8'd1);
    chk({tag, ".A_valid"}, {7'd0, A_valid}, 8'd0);
    chk({tag, ".A"},       {6'd0, A},       8'd0);
    chk({tag, ".cnt"},     word_cnt,        8'd0);
    chk({tag, ".err"},     {7'd0, err},     8'd0);
  endtask

  initial begin
    rst = 1'b1; D = 4'b0000; D_valid = 1'b0; A_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("rst");

    // Single bit word, latency 1, one emit cycle.
    D = 4'b0100; D_valid = 1'b1;
    tick();
    D_valid = 1'b0;
    chk("w1.A_valid", {7'd0, A_valid}, 8'd1);
    chk("w1.A",       {6'd0, A},       8'd2);
    chk("w1.D_ready", {7'd0, D_ready}, 8'd0);
    tick();
    chk("w1.idle",    {7'd0, A_valid}, 8'd0);
    chk("w1.D_ready2",{7'd0, D_ready}, 8'd1);
    chk("w1.cnt",     word_cnt,        8'd1);
    chk("w1.err",     {7'd0, err},     8'd0);

    // Multi-hot word, indices 3,1,0 back to back.
    D = 4'b1011; D_valid = 1'b1;
    tick();
    D_valid = 1'b0;
    chk("w2.A0", {5'd0, A_valid, A}, 8'h07);
    chk("w2.err", {7'd0, err}, ERR_EXP);
    tick();
    chk("w2.A1", {5'd0, A_valid, A}, 8'h05);
    chk("w2.cnt_mid", word_cnt, 8'd1);
    tick();
    chk("w2.A2", {5'd0, A_valid, A}, 8'h04);
    tick();
    chk("w2.idle", {7'd0, A_valid}, 8'd0);
    chk("w2.cnt", word_cnt, 8'd2);

    // Backpressure: A=3 held 5 cycles, D_valid pulse ignored.
    D = 4'b1000; D_valid = 1'b1; A_ready = 1'b0;
    tick();
    D_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) A_ready = 1'b1;
      chk("bp.A", {5'd0, A_valid, A}, 8'h07);
      chk("bp.D_ready", {7'd0, D_ready}, 8'd0);
      if (i == 1) begin D = 4'b0001; D_valid = 1'b1; end
      tick();
      D_valid = 1'b0;
    end
    chk("bp.idle", {7'd0, A_valid}, 8'd0);
    chk("bp.cnt", word_cnt, 8'd3);
    tick();
    chk("bp.noemit", {7'd0, A_valid}, 8'd0);

    // Zero word is dropped.
    D = 4'b0000; D_valid = 1'b1;
    tick();
    D_valid = 1'b0;
    chk("z.A_valid", {7'd0, A_valid}, 8'd0);
    chk("z.D_ready", {7'd0, D_ready}, 8'd1);
    tick();
    chk("z.cnt", word_cnt, 8'd3);

    // Reset mid-word discards the remaining bit.
    D = 4'b0110; D_valid = 1'b1;
    tick();
    D_valid = 1'b0;
    chk("mr.A0", {5'd0, A_valid, A}, 8'h06);
    tick();
    chk("mr.err", {7'd0, err}, ERR_EXP);
    A_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; A_ready = 1'b1;
    chk_reset_vals("mr");
    tick();
    chk("mr.noemit", {7'd0, A_valid}, 8'd0);

    // Reset wins over a simultaneous accept.
    D = 4'b0010; D_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; D_valid = 1'b0;
    chk("rp.A_valid", {7'd0, A_valid}, 8'd0);
    chk("rp.D_ready", {7'd0, D_ready}, 8'd1);

    // 256 single-bit words wrap the counter.
    for (int i = 0; i < 256; i++) begin
      D = 4'b0001; D_valid = 1'b1;
      tick();
      D_valid = 1'b0;
      if (i == 0) chk("wr.A", {5'd0, A_valid, A}, 8'h04);
      tick();
      if (i == 254) chk("wr.cnt255", word_cnt, 8'hFF);
    end
    chk("wr.cnt", word_cnt, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
